// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg
//   Shared definitions for the HI/LO multiply/divide sequencer:
//   - default datapath and iteration-counter widths
//   - R-type funct codes served by the sequencer
//   - sequencer FSM state encoding
//   - funct decode helpers
package muldiv_sequencer_pkg;

    localparam int unsigned MD_DWIDTH = 32;
    localparam int unsigned MD_CNT_W  = 5;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Any instruction that touches HI/LO.
    function automatic logic is_md_funct(input logic [5:0] funct);
        case (funct)
            FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: is_md_funct = 1'b1;
            default:                                        is_md_funct = 1'b0;
        endcase
    endfunction

    // Instructions that launch a multi-cycle operation.
    function automatic logic is_start_funct(input logic [5:0] funct);
        case (funct)
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: is_start_funct = 1'b1;
            default:                                        is_start_funct = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_sequencer_step.sv
// md_step_unit
//   Combinational single iteration of the sequential multiplier/divider,
//   operating on the {acc, q} register pair with operand m.
//   MUL: shift-add. If q[0], acc += m; then {carry, acc, q} >>= 1.
//        After DWIDTH steps {acc, q} holds the full 2*DWIDTH product.
//   DIV: restoring shift-subtract. {acc, q} <<= 1; if acc >= m, acc -= m
//        and the shifted-in quotient bit is 1. After DWIDTH steps
//        q = quotient, acc = remainder.
// Ports
//   is_div_i  in   1       select divide step (else multiply step)
//   acc_i     in   DWIDTH  accumulator / partial remainder
//   q_i       in   DWIDTH  multiplier (shifting out) / dividend-quotient
//   m_i       in   DWIDTH  multiplicand / divisor
//   acc_o     out  DWIDTH  next accumulator
//   q_o       out  DWIDTH  next q
module md_step_unit
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned DWIDTH = MD_DWIDTH
) (
    input  logic              is_div_i,
    input  logic [DWIDTH-1:0] acc_i,
    input  logic [DWIDTH-1:0] q_i,
    input  logic [DWIDTH-1:0] m_i,
    output logic [DWIDTH-1:0] acc_o,
    output logic [DWIDTH-1:0] q_o
);

    logic [DWIDTH:0]   mul_sum;
    logic [DWIDTH:0]   rem_shift;
    logic              rem_ge;
    logic [DWIDTH-1:0] rem_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_i} + (q_i[0] ? {1'b0, m_i} : '0);
        rem_shift = {acc_i, q_i[DWIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, m_i});
        // Only taken when rem_shift >= m, so the difference fits in DWIDTH bits.
        rem_diff  = rem_shift[DWIDTH-1:0] - m_i;

        if (is_div_i) begin
            acc_o = rem_ge ? rem_diff : rem_shift[DWIDTH-1:0];
            q_o   = {q_i[DWIDTH-2:0], rem_ge};
        end else begin
            acc_o = mul_sum[DWIDTH:1];
            q_o   = {mul_sum[0], q_i[DWIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle MULT/MULTU/DIV/DIVU engine beside the execute stage. Owns
//   HI/LO, serves MFHI/MFLO/MTHI/MTLO, and stalls the pipeline when an
//   HI/LO instruction reaches execute while an operation is in flight.
//   Timeline for an op accepted at edge T0: RUN in cycles T0+1..T0+32,
//   sign fix-up in T0+33, HI/LO visible from T0+34.
// Ports
//   md_i_clk      in   1       clock, rising edge
//   md_i_rst      in   1       synchronous active-high reset
//   md_i_ce       in   1       valid instruction in execute
//   md_i_rtype    in   1       opcode == 0
//   md_i_funct    in   6       funct field
//   md_i_flush    in   1       execute instruction is wrong-path
//   md_i_data_rs  in   DWIDTH  rs operand
//   md_i_data_rt  in   DWIDTH  rt operand
//   md_o_stall    out  1       hold IF/ID/EX (combinational)
//   md_o_busy     out  1       operation in flight
//   md_o_value    out  DWIDTH  HI for MFHI, LO for MFLO, else 0
//   md_o_value_ok out  1       md_o_value valid this cycle
//   md_o_hi       out  DWIDTH  architectural HI
//   md_o_lo       out  DWIDTH  architectural LO
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned DWIDTH = MD_DWIDTH,
    parameter int unsigned CNT_W  = MD_CNT_W
) (
    input  logic              md_i_clk,
    input  logic              md_i_rst,
    input  logic              md_i_ce,
    input  logic              md_i_rtype,
    input  logic [5:0]        md_i_funct,
    input  logic              md_i_flush,
    input  logic [DWIDTH-1:0] md_i_data_rs,
    input  logic [DWIDTH-1:0] md_i_data_rt,
    output logic              md_o_stall,
    output logic              md_o_busy,
    output logic [DWIDTH-1:0] md_o_value,
    output logic              md_o_value_ok,
    output logic [DWIDTH-1:0] md_o_hi,
    output logic [DWIDTH-1:0] md_o_lo
);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DWIDTH-1:0] acc_q;
    logic [DWIDTH-1:0] q_q;
    logic [DWIDTH-1:0] m_q;
    logic              is_div_q;
    logic              sign_quo_q;
    logic              sign_rem_q;
    logic [DWIDTH-1:0] hi_q;
    logic [DWIDTH-1:0] lo_q;

    logic              hit;
    logic              accept;
    logic              start;
    logic              op_div;
    logic              op_signed;
    logic              rs_neg;
    logic              rt_neg;
    logic              div_zero;
    logic [DWIDTH-1:0] rs_abs;
    logic [DWIDTH-1:0] rt_abs;
    logic              last_iter;

    logic [DWIDTH-1:0]   step_acc;
    logic [DWIDTH-1:0]   step_q;
    logic [2*DWIDTH-1:0] product;
    logic [DWIDTH-1:0]   hi_fix;
    logic [DWIDTH-1:0]   lo_fix;

    // ------------------------------------------------------------------
    // Instruction decode and operand conditioning
    // ------------------------------------------------------------------
    always_comb begin
        hit       = md_i_ce & md_i_rtype & ~md_i_flush & ~md_i_rst & is_md_funct(md_i_funct);
        accept    = hit & (state_q == MD_IDLE);
        start     = accept & is_start_funct(md_i_funct);
        op_div    = md_i_funct[1];
        op_signed = ~md_i_funct[0];
        rs_neg    = op_signed & md_i_data_rs[DWIDTH-1];
        rt_neg    = op_signed & md_i_data_rt[DWIDTH-1];
        rs_abs    = rs_neg ? -md_i_data_rs : md_i_data_rs;
        rt_abs    = rt_neg ? -md_i_data_rt : md_i_data_rt;
        div_zero  = op_div & (md_i_data_rt == '0);
        last_iter = (cnt_q == CNT_W'(DWIDTH - 1));
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge md_i_clk) begin
        if (md_i_rst) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE: if (start)     state_d = MD_RUN;
            MD_RUN:  if (last_iter) state_d = MD_FIX;
            MD_FIX:                 state_d = MD_IDLE;
            default:                state_d = MD_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        md_o_busy     = (state_q != MD_IDLE);
        md_o_stall    = hit & md_o_busy;
        md_o_value    = '0;
        md_o_value_ok = 1'b0;
        if (accept) begin
            if (md_i_funct == FUNCT_MFHI) begin
                md_o_value    = hi_q;
                md_o_value_ok = 1'b1;
            end else if (md_i_funct == FUNCT_MFLO) begin
                md_o_value    = lo_q;
                md_o_value_ok = 1'b1;
            end
        end
    end

    assign md_o_hi = hi_q;
    assign md_o_lo = lo_q;

    // ------------------------------------------------------------------
    // Arithmetic step and final sign correction
    // ------------------------------------------------------------------
    md_step_unit #(
        .DWIDTH (DWIDTH)
    ) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .q_i      (q_q),
        .m_i      (m_q),
        .acc_o    (step_acc),
        .q_o      (step_q)
    );

    always_comb begin
        product = {acc_q, q_q};
        if (sign_quo_q) begin
            product = -product;
        end
        if (is_div_q) begin
            hi_fix = sign_rem_q ? -acc_q : acc_q;
            lo_fix = sign_quo_q ? -q_q : q_q;
        end else begin
            hi_fix = product[2*DWIDTH-1:DWIDTH];
            lo_fix = product[DWIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath and HI/LO registers
    // ------------------------------------------------------------------
    always_ff @(posedge md_i_clk) begin
        if (md_i_rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            m_q        <= '0;
            is_div_q   <= 1'b0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        is_div_q <= op_div;
                        if (div_zero) begin
                            // Dividing the raw rs by zero with the restoring
                            // step yields quotient all-ones and remainder rs,
                            // which is exactly the required result, so the
                            // signs are suppressed rather than special-cased.
                            q_q        <= md_i_data_rs;
                            m_q        <= '0;
                            sign_quo_q <= 1'b0;
                            sign_rem_q <= 1'b0;
                        end else begin
                            q_q        <= op_div ? rs_abs : rt_abs;
                            m_q        <= op_div ? rt_abs : rs_abs;
                            sign_quo_q <= rs_neg ^ rt_neg;
                            sign_rem_q <= rs_neg;
                        end
                    end else if (accept && md_i_funct == FUNCT_MTHI) begin
                        hi_q <= md_i_data_rs;
                    end else if (accept && md_i_funct == FUNCT_MTLO) begin
                        lo_q <= md_i_data_rs;
                    end
                end
                MD_RUN: begin
                    acc_q <= step_acc;
                    q_q   <= step_q;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                MD_FIX: begin
                    hi_q  <= hi_fix;
                    lo_q  <= lo_fix;
                    cnt_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
